gigerx_pktfifo_1clk: RTL
========================

Name: gigerx_pktfifo_1clk

Overview:
- Single-clock, parametrised packet FIFO for the LMAC data path (e.g. RX MAC to host DMA). It is the successor to the dual-clock 256x64 FIFO.
- Write side stores packets speculatively. Each packet is committed on its end-of-packet word or rolled back on a drop/error, so the read side only ever sees complete, good packets.
- Adds end-of-packet tagging, a packet count, a programmable almost-full flag and overflow accounting.

Parameters:
- WIDTH, 64, data word width in bits.
- DEPTH, 256, number of entries; must equal 2**PTR.
- PTR, 8, address width; pointers are PTR+1 bits (extra wrap bit).
- AFULL_TH, 240, occupancy (write pointer minus read pointer) at or above which afull asserts; range 1..DEPTH.

Ports:
- clk  in  1  single clock for both sides.
- reset  in  1  synchronous, active-high reset.
- wrreq  in  1  write request.
- data  in  WIDTH  write data.
- wr_eop  in  1  qualifies the wrreq word as the last word of a packet.
- wr_drop  in  1  discard the currently open (uncommitted) packet.
- full  out  1  no free entry for a speculative write.
- afull  out  1  occupancy >= AFULL_TH.
- ovf  out  1  sticky: a packet was dropped because of overflow.
- drop_cnt  out  16  packets discarded by wr_drop or overflow; saturates at 0xFFFF.
- rdreq  in  1  read request.
- q  out  WIDTH  read data.
- q_eop  out  1  end-of-packet tag of q.
- empty  out  1  no committed word is available.
- usedw  out  PTR+1  committed words not yet read.
- pkt_cnt  out  PTR+1  committed packets whose eop word has not yet been read.

Behaviour:
- Storage: DEPTH x (WIDTH+1); bit WIDTH holds eop.
- Pointers, all PTR+1 bits, mod 2**(PTR+1):
  - wptr: speculative write pointer.
  - cptr: commit pointer.
  - rptr: read pointer.
- Registered flags, updated from next-state pointers:
  - full = (wptr - rptr) == DEPTH
  - afull = (wptr - rptr) >= AFULL_TH
  - empty = (cptr == rptr)
  - usedw = cptr - rptr
- Accepted write (wrreq & !full & !bad):
  - mem[wptr] <= {wr_eop, data}; wptr++.
  - If wr_eop: cptr <= wptr+1 and pkt_cnt++.
- Write-side state machine, states IDLE / OPEN / BAD:
  - IDLE -> OPEN on an accepted non-eop word.
  - OPEN -> IDLE on an accepted eop word (commit).
  - OPEN -> IDLE on wr_drop: wptr <= cptr, drop_cnt++.
  - IDLE/OPEN -> BAD on wrreq while full: word discarded, ovf <= 1.
  - BAD: all further words are ignored. On wrreq&wr_eop or on wr_drop: wptr <= cptr, drop_cnt++, -> IDLE.
  - A single-word packet (wrreq&wr_eop in IDLE) commits directly and the state stays IDLE.
- Simultaneous write events:
  - wr_drop with wrreq in the same cycle: drop wins; the word is not written.
  - wr_drop in IDLE: no-op, counter unchanged.
- Read, without the optional feature: rdreq & !empty -> q/q_eop <= mem[rptr] on the next edge (1-cycle latency); rptr++.
  - If the popped word has eop: pkt_cnt--.
  - rdreq while empty: ignored; q/q_eop hold their value.
- Simultaneous commit and pop: usedw and pkt_cnt apply both deltas in the same cycle (net change).
- A packet longer than the free space overflows and is dropped. The FIFO never deadlocks because the rollback frees space.
- Reset values: all pointers 0, state IDLE, q 0, q_eop 0, empty 1, full 0, afull 0, usedw 0, pkt_cnt 0, ovf 0, drop_cnt 0.
- Reset mid-packet or mid-read discards all contents. No requests are honoured in the reset cycle.

Optional Feature:
- Macro: LMAC_PKTFIFO_FWFT_EN.
- Defined (show-ahead): q/q_eop present mem[rptr] whenever empty==0, within the same cycle the word becomes visible. rdreq & !empty advances rptr, and the next word appears on the following edge. When empty, q/q_eop hold their last value.
- Undefined: standard 1-cycle read latency as described in Behaviour.

Test Plan:
- Reset, then write a 4-word packet 0x11..0x14 with eop on 0x14:
  - empty stays 1 until the cycle after the eop write, then usedw=4 and pkt_cnt=1.
  - Read 4 words -> q = 0x11,0x12,0x13,0x14 with q_eop=1 only on 0x14; pkt_cnt=0; empty=1.
- Write 3 words without eop, then pulse wr_drop:
  - usedw stays 0, empty=1, drop_cnt=1.
  - A following 2-word packet reads back intact.
- DEPTH=256: commit a 200-word packet, then write 60 words of a second packet:
  - full at occupancy 256; afull asserted from occupancy 240.
  - Word 57 of the second packet is attempted while full -> ovf=1.
  - The eop of the second packet triggers rollback: usedw=200, drop_cnt=1.
- Same cycle: wrreq&wr_eop on a 1-word packet plus rdreq popping the eop word of the previous packet -> pkt_cnt unchanged and usedw unchanged.
- Assert reset mid-packet with usedw=10 -> next cycle all outputs at reset values; subsequent traffic is normal.
- With LMAC_PKTFIFO_FWFT_EN, write 0xA5 with eop -> q=0xA5 and q_eop=1 while empty=0, before any rdreq. rdreq -> empty=1 on the next edge.

Source files
------------

// File: rtl/gigerx_pktfifo_1clk.sv
// gigerx_pktfifo_1clk: single-clock packet FIFO for the LMAC data path.
// The write side stores words speculatively behind a commit pointer. A packet
// is published to the read side on its eop word, or rolled back on wr_drop or
// overflow, so the reader only ever sees complete, good packets.
// Optional build macro: LMAC_PKTFIFO_FWFT_EN selects show-ahead read data.
// Without it, reads have one cycle of latency.
//
// Handshake: a word is written on any cycle with wrreq=1 and full=0, unless
// the write side is discarding an overflowed packet or wr_drop is high (drop
// wins). A word is popped on any cycle with rdreq=1 and empty=0. Requests
// made while full or empty are not stalled. An overflowing packet is
// discarded, and a read of an empty FIFO is ignored.
module gigerx_pktfifo_1clk #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 256,
    parameter int PTR      = 8,
    parameter int AFULL_TH = 240
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrreq,
    input  logic [WIDTH-1:0] data,
    input  logic             wr_eop,
    input  logic             wr_drop,
    output logic             full,
    output logic             afull,
    output logic             ovf,
    output logic [15:0]      drop_cnt,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             q_eop,
    output logic             empty,
    output logic [PTR:0]     usedw,
    output logic [PTR:0]     pkt_cnt,
    output logic [1:0]       wr_state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPEN = 2'd1,
        S_BAD  = 2'd2
    } wr_state_t;

    localparam logic [PTR:0] DEPTH_P = DEPTH[PTR:0];
    localparam logic [PTR:0] AFULL_P = AFULL_TH[PTR:0];

    wr_state_t      state, state_n;
    logic [PTR:0]   wptr, cptr, rptr;
    logic [PTR:0]   wptr_n, cptr_n, rptr_n;
    logic [PTR:0]   occ_n, pkt_cnt_n;
    logic           wr_en, commit, rollback, overflow, pop, pop_eop;
    logic [WIDTH:0] mem [DEPTH];
    logic [WIDTH:0] rd_word;

    assign rd_word      = mem[rptr[PTR-1:0]];
    assign wr_state_dbg = state;

    // Next-state pointers and write-side decisions for the current cycle
    always_comb begin
        state_n  = state;
        wptr_n   = wptr;
        cptr_n   = cptr;
        rptr_n   = rptr;
        wr_en    = 1'b0;
        commit   = 1'b0;
        rollback = 1'b0;
        overflow = 1'b0;
        pop      = rdreq & ~empty;
        pop_eop  = pop & rd_word[WIDTH];
        if (pop) begin
            rptr_n = rptr + 1'b1;
        end
        case (state)
            S_IDLE, S_OPEN: begin
                if (wr_drop) begin
                    // Dropping with no open packet is a no-op.
                    if (state == S_OPEN) begin
                        rollback = 1'b1;
                    end
                end else if (wrreq && full) begin
                    overflow = 1'b1;
                    // An eop word that overflows ends its packet right here,
                    // so discard it now instead of waiting for another eop.
                    if (wr_eop) begin
                        rollback = 1'b1;
                    end else begin
                        state_n = S_BAD;
                    end
                end else if (wrreq) begin
                    wr_en  = 1'b1;
                    wptr_n = wptr + 1'b1;
                    if (wr_eop) begin
                        commit  = 1'b1;
                        cptr_n  = wptr + 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_OPEN;
                    end
                end
            end
            S_BAD: begin
                if (wr_drop || (wrreq && wr_eop)) begin
                    rollback = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (rollback) begin
            wptr_n  = cptr;
            state_n = S_IDLE;
        end
        occ_n = wptr_n - rptr_n;
        case ({commit, pop_eop})
            2'b10:   pkt_cnt_n = pkt_cnt + 1'b1;
            2'b01:   pkt_cnt_n = pkt_cnt - 1'b1;
            default: pkt_cnt_n = pkt_cnt;
        endcase
    end

    // Pointers, write FSM and registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wptr     <= '0;
            cptr     <= '0;
            rptr     <= '0;
            full     <= 1'b0;
            afull    <= 1'b0;
            empty    <= 1'b1;
            usedw    <= '0;
            pkt_cnt  <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state   <= state_n;
            wptr    <= wptr_n;
            cptr    <= cptr_n;
            rptr    <= rptr_n;
            full    <= (occ_n == DEPTH_P);
            afull   <= (occ_n >= AFULL_P);
            empty   <= (cptr_n == rptr_n);
            usedw   <= cptr_n - rptr_n;
            pkt_cnt <= pkt_cnt_n;
            if (overflow) begin
                ovf <= 1'b1;
            end
            if (rollback && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Storage write; the eop tag lives in the top bit of each entry
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wptr[PTR-1:0]] <= {wr_eop, data};
        end
    end

`ifdef LMAC_PKTFIFO_FWFT_EN
    logic [WIDTH:0] hold;

    // Remember the head word so q holds its last value once the FIFO drains
    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
        end else if (!empty) begin
            hold <= rd_word;
        end
    end

    assign {q_eop, q} = empty ? hold : rd_word;
`else
    // Registered read port: popped word appears on the edge after rdreq
    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= '0;
            q_eop <= 1'b0;
        end else if (pop) begin
            {q_eop, q} <= rd_word;
        end
    end
`endif

endmodule
